// File: rtl/sweeper_pkg.sv
// Shared definitions for the truth-table sweeper family: FSM state encoding
// and the last-vector helper used to detect the end of a sweep.
package sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Highest input vector of an n_in-bit sweep (2^n_in - 1).
  function automatic logic [31:0] last_vec(input int unsigned n_in);
    last_vec = (32'd1 << n_in) - 32'd1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a registered zero flag; times how long a stimulus
// vector is held before its outputs are sampled.
module settle_timer #(
  parameter int SETTLE = 1,
  parameter int W      = $clog2(SETTLE + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_s;
  logic         zero_r;

  // Next count: load wins over decrement; decrement stops at zero.
  always_comb begin
    count_s = count_r;
    if (load) begin
      count_s = load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_s = count_r - W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Counter and zero flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
      zero_r  <= 1'b1;
    end else begin
      count_r <= count_s;
      zero_r  <= (count_s == {W{1'b0}});
    end
  end

  assign count = count_r;
  assign zero  = zero_r;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector, holds it SETTLE cycles,
// then compares two candidate outputs and records mismatch statistics.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic [N_OUT-1:0] y_a,
  input  logic [N_OUT-1:0] y_b,
  output logic            sample_valid,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0]   RELOAD     = TW'(SETTLE - 1);
  localparam logic [31:0]     LAST_VEC_W = last_vec(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC   = LAST_VEC_W[N_IN-1:0];

  state_t          state_r;
  state_t          state_s;
  logic            load_s;
  logic            dec_s;
  logic            zero_s;
  logic [TW-1:0]   count_s;
  logic            mismatch_s;
  logic            accept_s;

  logic [N_IN-1:0] vec_r;
  logic [N_IN-1:0] vec_s;
  logic [N_IN:0]   err_r;
  logic [N_IN:0]   err_s;
  logic [N_IN-1:0] fev_r;
  logic [N_IN-1:0] fev_s;
  logic            fevv_r;
  logic            fevv_s;
  logic            sample_valid_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;

  settle_timer #(
    .SETTLE (SETTLE),
    .W      (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (RELOAD),
    .dec      (dec_s),
    .count    (count_s),
    .zero     (zero_s)
  );

  assign accept_s   = ((state_r == S_IDLE) || (state_r == S_DONE)) && start;
  assign mismatch_s = (y_a != y_b);

  // Next-state and settle-timer control.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    dec_s   = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = S_APPLY;
          load_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_APPLY: begin
        if (zero_s) begin
          state_s = S_CHECK;
        end else begin
          dec_s = 1'b1;
        end
      end
      S_CHECK: begin
        if (vec_r == LAST_VEC) begin
          state_s = S_DONE;
        end else begin
          state_s = S_APPLY;
          load_s  = 1'b1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Vector stepping and mismatch bookkeeping.
  always_comb begin
    vec_s  = vec_r;
    err_s  = err_r;
    fev_s  = fev_r;
    fevv_s = fevv_r;
    if (accept_s) begin
      vec_s  = {N_IN{1'b0}};
      err_s  = {(N_IN+1){1'b0}};
      fevv_s = 1'b0;
    end else if (state_r == S_CHECK) begin
      if (mismatch_s) begin
        err_s = err_r + (N_IN+1)'(1);
        // Only the first mismatch of a sweep is captured.
        if (!fevv_r) begin
          fev_s  = vec_r;
          fevv_s = 1'b1;
        end else begin
          fev_s  = fev_r;
          fevv_s = fevv_r;
        end
      end else begin
        err_s = err_r;
      end
      if (vec_r != LAST_VEC) begin
        vec_s = vec_r + N_IN'(1);
      end else begin
        vec_s = vec_r;
      end
    end else begin
      vec_s = vec_r;
    end
  end

  // State, datapath and status output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      vec_r          <= {N_IN{1'b0}};
      err_r          <= {(N_IN+1){1'b0}};
      fev_r          <= {N_IN{1'b0}};
      fevv_r         <= 1'b0;
      sample_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      vec_r          <= vec_s;
      err_r          <= err_s;
      fev_r          <= fev_s;
      fevv_r         <= fevv_s;
      sample_valid_r <= (state_s == S_CHECK);
      busy_r         <= (state_s == S_APPLY) || (state_s == S_CHECK);
      done_r         <= (state_s == S_DONE);
      pass_r         <= (state_s == S_DONE) && (err_s == {(N_IN+1){1'b0}});
    end
  end

  assign vec             = vec_r;
  assign sample_valid    = sample_valid_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign err_count       = err_r;
  assign first_err_vec   = fev_r;
  assign first_err_valid = fevv_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed, scoreboard-based bench for truth_table_sweeper with two parameter
// sets (3-in/1-out/settle 1 and 4-in/2-out/settle 3).
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int qv[$];
  int qc[$];

  // ---------------- DUT 3: N_IN=3, N_OUT=1, SETTLE=1 ----------------
  logic       reset3, start3, sv3, busy3, done3, pass3, fevv3;
  logic [2:0] vec3, fev3;
  logic [3:0] ec3;
  logic [0:0] ya3, yb3;
  int         mode3 = 0;

  always_comb begin
    ya3 = (vec3[2] & vec3[1]) | ~vec3[0];
    case (mode3)
      1:       yb3 = (vec3 == 3'd5) ? ~ya3 : ya3;
      2:       yb3 = ~ya3;
      default: yb3 = ya3;
    endcase
  end

  truth_table_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(1)) dut3 (
    .clk(clk), .reset(reset3), .start(start3), .vec(vec3), .y_a(ya3), .y_b(yb3),
    .sample_valid(sv3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(ec3), .first_err_vec(fev3), .first_err_valid(fevv3)
  );

  // ---------------- DUT 4: N_IN=4, N_OUT=2, SETTLE=3 ----------------
  logic       reset4, start4, sv4, busy4, done4, pass4, fevv4;
  logic [3:0] vec4, fev4;
  logic [4:0] ec4;
  logic [1:0] ya4, yb4;

  always_comb begin
    ya4 = vec4[1:0] ^ vec4[3:2];
    yb4 = ((vec4 == 4'd9) || (vec4 == 4'd14)) ? (ya4 ^ 2'b10) : ya4;
  end

  truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(3)) dut4 (
    .clk(clk), .reset(reset4), .start(start4), .vec(vec4), .y_a(ya4), .y_b(yb4),
    .sample_valid(sv4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(ec4), .first_err_vec(fev4), .first_err_valid(fevv4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sweep on DUT 3; optional stray start during vec 2, optional reset abort at a vector.
  task automatic sweep3(input bit inject_start, input int abort_at);
    int k;
    bit seen_done;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start3 = 1'b0;
    check("acc3_busy", 32'(busy3), 32'd1);
    check("acc3_done", 32'(done3), 32'd0);
    check("acc3_pass", 32'(pass3), 32'd0);
    check("acc3_err",  32'(ec3),   32'd0);
    check("acc3_fevv", 32'(fevv3), 32'd0);
    check("acc3_vec",  32'(vec3),  32'd0);
    qv.delete();
    qc.delete();
    for (int i = 0; i < 8; i++) begin
      qv.push_back(i);
      qc.push_back(k + 1 + 2 * i);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk);
      start3 = (inject_start && busy3 && !sv3 && vec3 == 3'd2);
      if (abort_at >= 0 && busy3 && !sv3 && vec3 == 3'(abort_at)) begin
        reset3 = 1'b1;
        @(negedge clk);
        reset3 = 1'b0;
        check("rst_vec",  32'(vec3),  32'd0);
        check("rst_sv",   32'(sv3),   32'd0);
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_done", 32'(done3), 32'd0);
        check("rst_pass", 32'(pass3), 32'd0);
        check("rst_err",  32'(ec3),   32'd0);
        check("rst_fev",  32'(fev3),  32'd0);
        check("rst_fevv", 32'(fevv3), 32'd0);
        @(negedge clk);
        check("idle_busy", 32'(busy3), 32'd0);
        return;
      end
      if (sv3) begin
        check("sb3_extra", 32'(qv.size() > 0), 32'd1);
        if (qv.size() > 0) begin
          check("sb3_vec", 32'(vec3), 32'(qv.pop_front()));
          check("sb3_cyc", 32'(cyc),  32'(qc.pop_front()));
        end
      end
      if (done3) begin
        seen_done = 1'b1;
        check("done3_cyc", 32'(cyc), 32'(k + 16));
      end
    end
    start3 = 1'b0;
    check("done3_seen", 32'(seen_done), 32'd1);
    check("sb3_left",   32'(qv.size()), 32'd0);
  endtask

  task automatic result3(input int e_err, input int e_pass, input int e_fevv, input int e_fev);
    check("res3_done", 32'(done3), 32'd1);
    check("res3_busy", 32'(busy3), 32'd0);
    check("res3_vec",  32'(vec3),  32'd7);
    check("res3_pass", 32'(pass3), 32'(e_pass));
    check("res3_err",  32'(ec3),   32'(e_err));
    check("res3_fevv", 32'(fevv3), 32'(e_fevv));
    if (e_fevv != 0) check("res3_fev", 32'(fev3), 32'(e_fev));
  endtask

  task automatic sweep4();
    int k;
    bit seen_done;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start4 = 1'b0;
    check("acc4_busy", 32'(busy4), 32'd1);
    check("acc4_done", 32'(done4), 32'd0);
    check("acc4_pass", 32'(pass4), 32'd0);
    check("acc4_err",  32'(ec4),   32'd0);
    check("acc4_fevv", 32'(fevv4), 32'd0);
    check("acc4_vec",  32'(vec4),  32'd0);
    qv.delete();
    qc.delete();
    for (int i = 0; i < 16; i++) begin
      qv.push_back(i);
      qc.push_back(k + 3 + 4 * i);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (sv4) begin
        check("sb4_extra", 32'(qv.size() > 0), 32'd1);
        if (qv.size() > 0) begin
          check("sb4_vec", 32'(vec4), 32'(qv.pop_front()));
          check("sb4_cyc", 32'(cyc),  32'(qc.pop_front()));
        end
      end
      if (done4) begin
        seen_done = 1'b1;
        check("done4_cyc", 32'(cyc), 32'(k + 64));
      end
    end
    check("done4_seen", 32'(seen_done), 32'd1);
    check("sb4_left",   32'(qv.size()), 32'd0);
    check("res4_err",  32'(ec4),   32'd2);
    check("res4_pass", 32'(pass4), 32'd0);
    check("res4_fevv", 32'(fevv4), 32'd1);
    check("res4_fev",  32'(fev4),  32'd9);
    check("res4_vec",  32'(vec4),  32'd15);
  endtask

  initial begin
    reset3 = 1'b1;
    reset4 = 1'b1;
    start3 = 1'b0;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset3 = 1'b0;
    reset4 = 1'b0;
    check("por_vec",  32'(vec3),  32'd0);
    check("por_sv",   32'(sv3),   32'd0);
    check("por_busy", 32'(busy3), 32'd0);
    check("por_done", 32'(done3), 32'd0);
    check("por_pass", 32'(pass3), 32'd0);
    check("por_err",  32'(ec3),   32'd0);
    check("por_fevv", 32'(fevv3), 32'd0);
    check("por_busy4", 32'(busy4), 32'd0);

    // Matching candidates
    mode3 = 0;
    sweep3(1'b0, -1);
    result3(0, 1, 0, 0);

    // Single mismatch at vector 5
    mode3 = 1;
    sweep3(1'b0, -1);
    result3(1, 0, 1, 5);

    // Every vector mismatches
    mode3 = 2;
    sweep3(1'b0, -1);
    result3(8, 0, 1, 0);

    // Stray start while busy is ignored
    mode3 = 0;
    sweep3(1'b1, -1);
    result3(0, 1, 0, 0);

    // Reset mid-sweep, then a clean sweep
    mode3 = 1;
    sweep3(1'b0, 3);
    mode3 = 0;
    sweep3(1'b0, -1);
    result3(0, 1, 0, 0);

    // Wider configuration, then restart from DONE
    sweep4();
    sweep4();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-checking exhaustive stimulus engine for small combinational functions.
- Walks every input vector 0..2^N_IN-1 and drives it to two candidate implementations of the same function, for example a gate-level and an operator-level version.
- Samples both outputs after a settle time, compares them, and reports pass/fail, mismatch count and the first failing vector.
- Replaces hand-written delay-step truth-table stimulus in lab benches and on-board checkers.

Parameters:
N_IN, 3, input vector width; number of vectors swept = 2^N_IN.
N_OUT, 1, width of each candidate output.
SETTLE, 1, cycles each vector is held before compare; must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  begin a sweep; sampled only in IDLE or DONE.
vec  out  N_IN  input vector driven to both candidates.
y_a  in  N_OUT  output of candidate A (reference implementation).
y_b  in  N_OUT  output of candidate B (implementation under check).
sample_valid  out  1  one-cycle strobe; vec/y_a/y_b are valid for logging this cycle.
busy  out  1  high from the cycle after accepted start until sweep end.
done  out  1  high in DONE; held until next start or reset.
pass  out  1  valid when done=1; 1 iff err_count == 0.
err_count  out  N_IN+1  number of mismatching vectors; never saturates, since max is 2^N_IN.
first_err_vec  out  N_IN  vector of the first mismatch.
first_err_valid  out  1  first_err_vec holds a captured vector.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; vec, err_count and first_err_vec = 0; sample_valid, busy, done, pass and first_err_valid = 0. Reset mid-sweep aborts immediately with the same values; no partial result is kept.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE: start=1 -> APPLY; vec=0, err_count=0, first_err_valid=0, settle counter=SETTLE-1, busy=1.
- APPLY: vec is held stable. If settle counter == 0 -> CHECK; otherwise decrement. APPLY therefore lasts exactly SETTLE cycles.
- CHECK (1 cycle): sample_valid=1. If y_a != y_b (full N_OUT-bit compare):
  - err_count += 1;
  - if first_err_valid=0, capture first_err_vec=vec and set first_err_valid=1.
- Exit from CHECK:
  - vec == 2^N_IN-1 -> DONE.
  - Otherwise vec <= vec+1 (no wrap inside a sweep), reload settle counter, return to APPLY.
- DONE: busy=0, done=1, pass=(err_count==0). vec holds its last value. start=1 -> restart exactly as from IDLE, clearing done, pass and the counters in the same edge.
- start is ignored in APPLY and CHECK; no queuing.
- Latency: start accepted at edge k. The first CHECK occurs at cycle k+SETTLE. done rises at edge k + 2^N_IN*(SETTLE+1).
- Candidates are combinational. A sample is taken only in CHECK, so glitches during APPLY are irrelevant.

Decomposition:
- Shared package `sweeper_pkg`:
  - state encoding constants S_IDLE=2'd0, S_APPLY=2'd1, S_CHECK=2'd2, S_DONE=2'd3;
  - function for the last-vector constant (2^N_IN-1).
- One natural sub-module: `settle_timer`. Loadable down-counter sized $clog2(SETTLE+1) with a zero flag. It is reused by later lab checkers.
- Compare logic and mismatch capture stay inline in the top.

Test Plan:
1. N_IN=3, SETTLE=1, y_a and y_b both = (A&B)|~C, pulse start -> 8 sample_valid strobes for vec 0..7; done at start+16 cycles; pass=1; err_count=0; first_err_valid=0.
2. Same, but y_b inverted only when vec==5 -> err_count=1, first_err_vec=5, first_err_valid=1, pass=0.
3. y_b = ~y_a for all vectors -> err_count=8, first_err_vec=0, pass=0.
4. Pulse start again while busy, during vec=2 -> ignored; sweep completes at the original cycle count with the same results as scenario 1.
5. Assert reset for 1 cycle while vec=3 in APPLY -> next cycle all outputs 0, state IDLE. A new start gives a full clean sweep from vec 0.
6. N_IN=4, N_OUT=2, SETTLE=3, y_b differs from y_a in bit 1 only, for vec 9 and 14 -> 16 strobes, each 4 cycles apart; done at start+64; err_count=2; first_err_vec=9. Then start from DONE -> counters clear on the accept edge.
